// File: rtl/mem_dma.sv
// Block copy / fill DMA engine for a word-addressed memory with combinational read data.
// Copies take a READ then a WRITE cycle per word; fills issue one WRITE per cycle.
module mem_dma #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  fill_mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] words_done,
    output logic [ADDR_WIDTH-1:0] mem_access_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   src_ptr_q, src_ptr_d;
    logic [ADDR_WIDTH-1:0]   dst_ptr_q, dst_ptr_d;
    logic [ADDR_WIDTH-1:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]   words_done_q, words_done_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d;
    logic                    fill_mode_q, fill_mode_d;
    logic [DATA_WIDTH-1:0]   fill_value_q, fill_value_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            buf_q        <= '0;
            fill_mode_q  <= 1'b0;
            fill_value_q <= '0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            buf_q        <= buf_d;
            fill_mode_q  <= fill_mode_d;
            fill_value_q <= fill_value_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        buf_d        = buf_q;
        fill_mode_d  = fill_mode_q;
        fill_value_d = fill_value_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_ptr_d    = src_addr;
                    dst_ptr_d    = dst_addr;
                    remaining_d  = length;
                    words_done_d = '0;
                    fill_mode_d  = fill_mode;
                    fill_value_d = fill_value;
                    if (length == '0)
                        state_d = S_DONE;
                    else if (fill_mode)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                buf_d   = mem_read_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                src_ptr_d    = src_ptr_q + ONE_A;
                dst_ptr_d    = dst_ptr_q + ONE_A;
                words_done_d = words_done_q + ONE_A;
                remaining_d  = remaining_q - ONE_A;
                if (remaining_q == ONE_A)
                    state_d = S_DONE;
                else if (fill_mode_q)
                    state_d = S_WRITE;
                else
                    state_d = S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-side outputs depend only on registered state, never on request inputs.
    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        case (state_q)
            S_READ: mem_access_addr = src_ptr_q;
            S_WRITE: begin
                mem_access_addr = dst_ptr_q;
                mem_write_data  = fill_mode_q ? fill_value_q : buf_q;
                mem_write_en    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign words_done = words_done_q;

endmodule
